csr_regfile: RTL and testbench

- Machine-mode CSR storage for the RV32 core. It is the consuming end of the writeback CSR channel (wb_csr_reg_we / write_addr / data) that leaves the MEM/WB pipeline register.
- Serves the execute stage's combinational CSR read port, with same-cycle write bypass.
- Accepts trap-entry and mret updates from the exception control path.
- Keeps the mcycle/minstret counters and drives the timer-interrupt request back to control.

---
 rtl/csr_regfile_pkg.sv | 71 +++++++
 rtl/csr_regfile_counter64.sv | 39 +++
 rtl/csr_regfile.sv | 184 ++++++++++++++++++
 tb/tb_csr_regfile.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/csr_regfile_pkg.sv
// csr_regfile_pkg
//   Shared constants and helpers for the machine-mode CSR file. This package holds:
//   - the CSR addresses,
//   - the mstatus/mie/mip bit positions,
//   - the write masks,
//   - a helper that turns raw write data into the value a CSR will hold.
//   The read bypass and the write path both use that helper, so the two cannot disagree.
package csr_regfile_pkg;

    // CSR addresses
    localparam logic [11:0] CSR_MSTATUS   = 12'h300;
    localparam logic [11:0] CSR_MISA      = 12'h301;
    localparam logic [11:0] CSR_MIE       = 12'h304;
    localparam logic [11:0] CSR_MTVEC     = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
    localparam logic [11:0] CSR_MEPC      = 12'h341;
    localparam logic [11:0] CSR_MCAUSE    = 12'h342;
    localparam logic [11:0] CSR_MTVAL     = 12'h343;
    localparam logic [11:0] CSR_MIP       = 12'h344;
    localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
    localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
    localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
    localparam logic [11:0] CSR_MHARTID   = 12'hF14;

    // mstatus fields
    localparam int MSTATUS_MIE    = 3;
    localparam int MSTATUS_MPIE   = 7;
    localparam int MSTATUS_MPP_LO = 11;
    localparam int MSTATUS_MPP_HI = 12;

    // MTIE in mie and MTIP in mip share bit 7
    localparam int MIX_MT_BIT = 7;

    // Write masks
    localparam logic [31:0] MSTATUS_WMASK = 32'h0000_0088;  // MIE | MPIE
    localparam logic [31:0] MSTATUS_MPP   = 32'h0000_1800;  // hardwired M-mode
    localparam logic [31:0] MIE_WMASK     = 32'h0000_0080;  // MTIE only
    localparam logic [31:0] ALIGN4_MASK   = 32'hFFFF_FFFC;  // mepc / mtvec

    // True for addresses a write can land on
    function automatic logic csr_writable(input logic [11:0] addr);
        case (addr)
            CSR_MSTATUS, CSR_MIE, CSR_MTVEC, CSR_MSCRATCH,
            CSR_MEPC, CSR_MCAUSE, CSR_MTVAL,
            CSR_MCYCLE, CSR_MINSTRET, CSR_MCYCLEH, CSR_MINSTRETH:
                csr_writable = 1'b1;
            default:
                csr_writable = 1'b0;
        endcase
    endfunction

    // Value a register reads back after a write of 'data' to 'addr'
    function automatic logic [31:0] csr_write_view(input logic [11:0] addr,
                                                   input logic [31:0] data);
        case (addr)
            CSR_MSTATUS:
                csr_write_view = (data & MSTATUS_WMASK) | MSTATUS_MPP;
            CSR_MIE:
                csr_write_view = data & MIE_WMASK;
            CSR_MTVEC, CSR_MEPC:
                csr_write_view = data & ALIGN4_MASK;
            CSR_MSCRATCH, CSR_MCAUSE, CSR_MTVAL,
            CSR_MCYCLE, CSR_MINSTRET, CSR_MCYCLEH, CSR_MINSTRETH:
                csr_write_view = data;
            default:
                csr_write_view = 32'h0;
        endcase
    endfunction

endpackage

// File: rtl/csr_regfile_counter64.sv
// csr_counter64
//   64-bit free-running counter with separate write strobes for the low and high halves.
//   - A write replaces the written half.
//   - In a write cycle the other half holds and the counter does not increment.
//   - The count wraps from all-ones to zero.
//   Ports:
//     clk, rst   clock, synchronous active-high reset
//     inc_i      increment enable
//     wr_lo_i    write bits 31:0 from wdata_i
//     wr_hi_i    write bits 63:32 from wdata_i
//     wdata_i    write data
//     count_o    current count
module csr_counter64 (
    input  logic        clk,
    input  logic        rst,
    input  logic        inc_i,
    input  logic        wr_lo_i,
    input  logic        wr_hi_i,
    input  logic [31:0] wdata_i,
    output logic [63:0] count_o
);

    logic [63:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= 64'h0;
        end else if (wr_lo_i) begin
            r_cnt[31:0] <= wdata_i;
        end else if (wr_hi_i) begin
            r_cnt[63:32] <= wdata_i;
        end else if (inc_i) begin
            r_cnt <= r_cnt + 64'd1;
        end
    end

    assign count_o = r_cnt;

endmodule

// File: rtl/csr_regfile.sv
// csr_regfile
//   Machine-mode CSR storage for the RV32 core.
//   - Takes the writeback CSR write channel.
//   - Serves the execute stage's combinational read port, with same-cycle write bypass.
//   - Applies trap-entry and mret updates.
//   - Keeps the mcycle and minstret counters.
//   - Raises a registered timer-interrupt request.
//   Ports:
//     clk, rst                   clock, synchronous active-high reset
//     we_i, waddr_i, wdata_i     CSR write from writeback
//     raddr_i, rdata_o           combinational CSR read
//     trap_i, trap_pc_i,
//     trap_cause_i, trap_val_i   trap entry (loads mepc/mcause/mtval)
//     mret_i                     mret commit
//     instret_i                  retire strobe for minstret
//     timer_irq_i                CLINT timer level
//     mtvec_o, mepc_o            current trap vector / exception PC
//     irq_o                      registered MIE & MTIE & MTIP
module csr_regfile
    import csr_regfile_pkg::*;
#(
    parameter logic [31:0] HART_ID   = 32'h0,
    parameter logic [31:0] MISA_VAL  = 32'h4000_0100,
    parameter logic [31:0] MTVEC_RST = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        we_i,
    input  logic [11:0] waddr_i,
    input  logic [31:0] wdata_i,
    input  logic [11:0] raddr_i,
    output logic [31:0] rdata_o,
    input  logic        trap_i,
    input  logic [31:0] trap_pc_i,
    input  logic [31:0] trap_cause_i,
    input  logic [31:0] trap_val_i,
    input  logic        mret_i,
    input  logic        instret_i,
    input  logic        timer_irq_i,
    output logic [31:0] mtvec_o,
    output logic [31:0] mepc_o,
    output logic        irq_o
);

    // Architectural state
    logic        r_mie;      // mstatus.MIE
    logic        r_mpie;     // mstatus.MPIE
    logic        r_mtie;     // mie.MTIE
    logic        r_mtip;     // mip.MTIP (timer_irq_i, one flop)
    logic        r_irq;
    logic [31:0] r_mtvec;
    logic [31:0] r_mscratch;
    logic [31:0] r_mepc;
    logic [31:0] r_mcause;
    logic [31:0] r_mtval;

    logic [63:0] w_mcycle;
    logic [63:0] w_minstret;
    logic [31:0] w_mstatus;
    logic [31:0] w_wview;
    logic [31:0] w_rdata;
    logic        w_wr_mstatus, w_wr_mie, w_wr_mtvec, w_wr_mscratch;
    logic        w_wr_mepc, w_wr_mcause, w_wr_mtval;
    logic        w_wr_mcycle, w_wr_mcycleh, w_wr_minstret, w_wr_minstreth;

    // Write decode
    assign w_wr_mstatus   = we_i && (waddr_i == CSR_MSTATUS);
    assign w_wr_mie       = we_i && (waddr_i == CSR_MIE);
    assign w_wr_mtvec     = we_i && (waddr_i == CSR_MTVEC);
    assign w_wr_mscratch  = we_i && (waddr_i == CSR_MSCRATCH);
    assign w_wr_mepc      = we_i && (waddr_i == CSR_MEPC);
    assign w_wr_mcause    = we_i && (waddr_i == CSR_MCAUSE);
    assign w_wr_mtval     = we_i && (waddr_i == CSR_MTVAL);
    assign w_wr_mcycle    = we_i && (waddr_i == CSR_MCYCLE);
    assign w_wr_mcycleh   = we_i && (waddr_i == CSR_MCYCLEH);
    assign w_wr_minstret  = we_i && (waddr_i == CSR_MINSTRET);
    assign w_wr_minstreth = we_i && (waddr_i == CSR_MINSTRETH);

    assign w_wview = csr_write_view(waddr_i, wdata_i);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mie      <= 1'b0;
            r_mpie     <= 1'b0;
            r_mtie     <= 1'b0;
            r_mtip     <= 1'b0;
            r_irq      <= 1'b0;
            r_mtvec    <= MTVEC_RST;
            r_mscratch <= 32'h0;
            r_mepc     <= 32'h0;
            r_mcause   <= 32'h0;
            r_mtval    <= 32'h0;
        end else begin
            // mstatus: trap beats mret, and both beat a software write.
            // mret touches both writable fields, so it fully shadows a write.
            if (trap_i) begin
                r_mpie <= r_mie;
                r_mie  <= 1'b0;
            end else if (mret_i) begin
                r_mie  <= r_mpie;
                r_mpie <= 1'b1;
            end else if (w_wr_mstatus) begin
                r_mie  <= wdata_i[MSTATUS_MIE];
                r_mpie <= wdata_i[MSTATUS_MPIE];
            end

            // Trap-owned registers. Writes elsewhere in the map still land.
            if (trap_i) begin
                r_mepc   <= trap_pc_i & ALIGN4_MASK;
                r_mcause <= trap_cause_i;
                r_mtval  <= trap_val_i;
            end else begin
                if (w_wr_mepc)   r_mepc   <= w_wview;
                if (w_wr_mcause) r_mcause <= w_wview;
                if (w_wr_mtval)  r_mtval  <= w_wview;
            end

            if (w_wr_mie)      r_mtie     <= wdata_i[MIX_MT_BIT];
            if (w_wr_mtvec)    r_mtvec    <= w_wview;
            if (w_wr_mscratch) r_mscratch <= w_wview;

            r_mtip <= timer_irq_i;
            // Built from registered terms, so irq_o lags its inputs by one edge
            r_irq  <= r_mie & r_mtie & r_mtip;
        end
    end

    csr_counter64 u_mcycle (
        .clk     (clk),
        .rst     (rst),
        .inc_i   (1'b1),
        .wr_lo_i (w_wr_mcycle),
        .wr_hi_i (w_wr_mcycleh),
        .wdata_i (wdata_i),
        .count_o (w_mcycle)
    );

    csr_counter64 u_minstret (
        .clk     (clk),
        .rst     (rst),
        .inc_i   (instret_i),
        .wr_lo_i (w_wr_minstret),
        .wr_hi_i (w_wr_minstreth),
        .wdata_i (wdata_i),
        .count_o (w_minstret)
    );

    always_comb begin
        w_mstatus                 = MSTATUS_MPP;
        w_mstatus[MSTATUS_MIE]    = r_mie;
        w_mstatus[MSTATUS_MPIE]   = r_mpie;
    end

    always_comb begin
        w_rdata = 32'h0;
        case (raddr_i)
            CSR_MSTATUS:   w_rdata = w_mstatus;
            CSR_MISA:      w_rdata = MISA_VAL;
            CSR_MIE:       w_rdata = {24'h0, r_mtie, 7'h0};
            CSR_MTVEC:     w_rdata = r_mtvec;
            CSR_MSCRATCH:  w_rdata = r_mscratch;
            CSR_MEPC:      w_rdata = r_mepc;
            CSR_MCAUSE:    w_rdata = r_mcause;
            CSR_MTVAL:     w_rdata = r_mtval;
            CSR_MIP:       w_rdata = {24'h0, r_mtip, 7'h0};
            CSR_MCYCLE:    w_rdata = w_mcycle[31:0];
            CSR_MINSTRET:  w_rdata = w_minstret[31:0];
            CSR_MCYCLEH:   w_rdata = w_mcycle[63:32];
            CSR_MINSTRETH: w_rdata = w_minstret[63:32];
            CSR_MHARTID:   w_rdata = HART_ID;
            default:       w_rdata = 32'h0;
        endcase
    end

    // Forward an in-flight writeback so execute sees it without a stall.
    // Trap/mret effects are intentionally not forwarded.
    assign rdata_o = (we_i && (waddr_i == raddr_i) && csr_writable(raddr_i))
                     ? w_wview : w_rdata;

    assign mtvec_o = r_mtvec;
    assign mepc_o  = r_mepc;
    assign irq_o   = r_irq;

endmodule

// File: tb/tb_csr_regfile.sv
module tb_csr_regfile;

    localparam logic [11:0] A_MSTATUS = 12'h300, A_MISA = 12'h301, A_MIE = 12'h304;
    localparam logic [11:0] A_MTVEC = 12'h305, A_MSCRATCH = 12'h340, A_MEPC = 12'h341;
    localparam logic [11:0] A_MCAUSE = 12'h342, A_MTVAL = 12'h343, A_MIP = 12'h344;
    localparam logic [11:0] A_MCYCLE = 12'hB00, A_MINSTRET = 12'hB02;
    localparam logic [11:0] A_MCYCLEH = 12'hB80, A_MINSTRETH = 12'hB82, A_MHARTID = 12'hF14;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        we_i = 1'b0;
    logic [11:0] waddr_i = 12'h0;
    logic [31:0] wdata_i = 32'h0;
    logic [11:0] raddr_i = 12'h0;
    logic [31:0] rdata_o;
    logic        trap_i = 1'b0;
    logic [31:0] trap_pc_i = 32'h0;
    logic [31:0] trap_cause_i = 32'h0;
    logic [31:0] trap_val_i = 32'h0;
    logic        mret_i = 1'b0;
    logic        instret_i = 1'b0;
    logic        timer_irq_i = 1'b0;
    logic [31:0] mtvec_o;
    logic [31:0] mepc_o;
    logic        irq_o;

    logic [31:0] sb[$];
    logic [31:0] d, e;
    int          nvec = 0;
    int          nmis = 0;

    csr_regfile #(.HART_ID(32'h0), .MISA_VAL(32'h4000_0100), .MTVEC_RST(32'h0)) dut (
        .clk(clk), .rst(rst), .we_i(we_i), .waddr_i(waddr_i), .wdata_i(wdata_i),
        .raddr_i(raddr_i), .rdata_o(rdata_o), .trap_i(trap_i), .trap_pc_i(trap_pc_i),
        .trap_cause_i(trap_cause_i), .trap_val_i(trap_val_i), .mret_i(mret_i),
        .instret_i(instret_i), .timer_irq_i(timer_irq_i), .mtvec_o(mtvec_o),
        .mepc_o(mepc_o), .irq_o(irq_o)
    );

    always #5 clk = ~clk;

    // Inputs change on the falling edge; reads settle 1 time unit later.
    task automatic wr(input logic [11:0] a, input logic [31:0] v);
        we_i = 1'b1; waddr_i = a; wdata_i = v;
        @(negedge clk);
        we_i = 1'b0;
    endtask

    task automatic rd(input logic [11:0] a, output logic [31:0] v);
        raddr_i = a;
        #1;
        v = rdata_o;
    endtask

    task automatic test_reset;
        sb.push_back(32'h0); d = mtvec_o; e = sb.pop_front(); nvec++;
        if (d !== e) begin nmis++; $display("FAIL rst_mtvec: got %h want %h", d, e); end
        sb.push_back(32'h0000_1800); rd(A_MSTATUS, d); e = sb.pop_front(); nvec++;
        if (d !== e) begin nmis++; $display("FAIL rst_mstatus: got %h want %h", d, e); end
        sb.push_back(32'h0); rd(A_MHARTID, d); e = sb.pop_front(); nvec++;
        if (d !== e) begin nmis++; $display("FAIL rst_mhartid: got %h want %h", d, e); end
        sb.push_back(32'h4000_0100); rd(A_MISA, d); e = sb.pop_front(); nvec++;
        if (d !== e) begin nmis++; $display("FAIL rst_misa: got %h want %h", d, e); end
        sb.push_back(32'h0); d = {31'h0, irq_o}; e = sb.pop_front(); nvec++;
        if (d !== e) begin nmis++; $display("FAIL rst_irq: got %h want %h", d, e); end
        sb.push_back(32'h0); rd(A_MIP, d); e = sb.pop_front(); nvec++;
        if (d !== e) begin nmis++; $display("FAIL rst_mip: got %h want %h", d, e); end
        sb.push_back(32'h0); rd(A_MCYCLE, d); e = sb.pop_front(); nvec++;
        if (d !== e) begin nmis++; $display("FAIL rst_mcycle: got %h want %h", d, e); end
    endtask

    task automatic test_write_masks;
        we_i = 1'b1; waddr_i = A_MSTATUS; wdata_i = 32'hFFFF_FFFF;
        sb.push_back(32'h0000_1888); rd(A_MSTATUS, d); e = sb.pop_front(); nvec++;
        if (d !== e) begin nmis++; $display("FAIL mstatus_bypass: got %h want %h", d, e); end
        @(negedge clk); we_i = 1'b0;
        sb.push_back(32'h0000_1888); rd(A_MSTATUS, d); e = sb.pop_front(); nvec++;
        if (d !== e) begin nmis++; $display("FAIL mstatus_stored: got %h want %h", d, e); end
        wr(A_MEPC, 32'h8000_0007);
        sb.push_back(32'h8000_0004); rd(A_MEPC, d); e = sb.pop_front(); nvec++;
        if (d !== e) begin nmis++; $display("FAIL mepc_mask: got %h want %h", d, e); end
        sb.push_back(32'h8000_0004); d = mepc_o; e = sb.pop_front(); nvec++;
        if (d !== e) begin nmis++; $display("FAIL mepc_o: got %h want %h", d, e); end
        wr(A_MTVEC, 32'h1234_5677);
        sb.push_back(32'h1234_5674); d = mtvec_o; e = sb.pop_front(); nvec++;
        if (d !== e) begin nmis++; $display("FAIL mtvec_mask: got %h want %h", d, e); end
        wr(A_MIE, 32'hFFFF_FFFF);
        sb.push_back(32'h0000_0080); rd(A_MIE, d); e = sb.pop_front(); nvec++;
        if (d !== e) begin nmis++; $display("FAIL mie_mask: got %h want %h", d, e); end
        wr(A_MISA, 32'h0);
        sb.push_back(32'h4000_0100); rd(A_MISA, d); e = sb.pop_front(); nvec++;
        if (d !== e) begin nmis++; $display("FAIL misa_ro: got %h want %h", d, e); end
        wr(A_MSCRATCH, 32'hA5A5_A5A5);
        sb.push_back(32'hA5A5_A5A5); rd(A_MSCRATCH, d); e = sb.pop_front(); nvec++;
        if (d !== e) begin nmis++; $display("FAIL mscratch: got %h want %h", d, e); end
        we_i = 1'b1; waddr_i = 12'h7C0; wdata_i = 32'hFFFF_FFFF;
        sb.push_back(32'h0); rd(12'h7C0, d); e = sb.pop_front(); nvec++;
        if (d !== e) begin nmis++; $display("FAIL unmapped_read: got %h want %h", d, e); end
        @(negedge clk); we_i = 1'b0;
    endtask

    task automatic test_trap_mret;
        wr(A_MSTATUS, 32'h8);
        wr(A_MTVAL, 32'h1234);
        trap_i = 1'b1; trap_pc_i = 32'h100; trap_cause_i = 32'h8000_0007; trap_val_i = 32'h0;
        sb.push_back(32'h0000_1808); rd(A_MSTATUS, d); e = sb.pop_front(); nvec++;
        if (d !== e) begin nmis++; $display("FAIL trap_no_bypass: got %h want %h", d, e); end
        @(negedge clk); trap_i = 1'b0;
        sb.push_back(32'h100); rd(A_MEPC, d); e = sb.pop_front(); nvec++;
        if (d !== e) begin nmis++; $display("FAIL trap_mepc: got %h want %h", d, e); end
        sb.push_back(32'h8000_0007); rd(A_MCAUSE, d); e = sb.pop_front(); nvec++;
        if (d !== e) begin nmis++; $display("FAIL trap_mcause: got %h want %h", d, e); end
        sb.push_back(32'h0); rd(A_MTVAL, d); e = sb.pop_front(); nvec++;
        if (d !== e) begin nmis++; $display("FAIL trap_mtval: got %h want %h", d, e); end
        sb.push_back(32'h0000_1880); rd(A_MSTATUS, d); e = sb.pop_front(); nvec++;
        if (d !== e) begin nmis++; $display("FAIL trap_mstatus: got %h want %h", d, e); end
        mret_i = 1'b1;
        @(negedge clk); mret_i = 1'b0;
        sb.push_back(32'h0000_1888); rd(A_MSTATUS, d); e = sb.pop_front(); nvec++;
        if (d !== e) begin nmis++; $display("FAIL mret_mstatus: got %h want %h", d, e); end
    endtask

    task automatic test_irq;
        wr(A_MSTATUS, 32'h8);
        wr(A_MIE, 32'h80);
        timer_irq_i = 1'b1;
        @(negedge clk);
        sb.push_back(32'h80); rd(A_MIP, d); e = sb.pop_front(); nvec++;
        if (d !== e) begin nmis++; $display("FAIL irq_mip: got %h want %h", d, e); end
        sb.push_back(32'h0); d = {31'h0, irq_o}; e = sb.pop_front(); nvec++;
        if (d !== e) begin nmis++; $display("FAIL irq_lag1: got %h want %h", d, e); end
        @(negedge clk);
        sb.push_back(32'h1); d = {31'h0, irq_o}; e = sb.pop_front(); nvec++;
        if (d !== e) begin nmis++; $display("FAIL irq_set: got %h want %h", d, e); end
        trap_i = 1'b1; trap_pc_i = 32'h200; trap_cause_i = 32'h8000_0007; trap_val_i = 32'h0;
        @(negedge clk); trap_i = 1'b0;
        sb.push_back(32'h1); d = {31'h0, irq_o}; e = sb.pop_front(); nvec++;
        if (d !== e) begin nmis++; $display("FAIL irq_hold_trap_edge: got %h want %h", d, e); end
        @(negedge clk);
        sb.push_back(32'h0); d = {31'h0, irq_o}; e = sb.pop_front(); nvec++;
        if (d !== e) begin nmis++; $display("FAIL irq_drop: got %h want %h", d, e); end
        timer_irq_i = 1'b0;
    endtask

    task automatic test_counters;
        wr(A_MCYCLE, 32'hFFFF_FFFE);
        wr(A_MCYCLEH, 32'h0);
        sb.push_back(32'hFFFF_FFFE); rd(A_MCYCLE, d); e = sb.pop_front(); nvec++;
        if (d !== e) begin nmis++; $display("FAIL mcycle_hold_on_hi_wr: got %h want %h", d, e); end
        repeat (2) @(negedge clk);
        sb.push_back(32'h0); rd(A_MCYCLE, d); e = sb.pop_front(); nvec++;
        if (d !== e) begin nmis++; $display("FAIL mcycle_carry_lo: got %h want %h", d, e); end
        sb.push_back(32'h1); rd(A_MCYCLEH, d); e = sb.pop_front(); nvec++;
        if (d !== e) begin nmis++; $display("FAIL mcycle_carry_hi: got %h want %h", d, e); end
        wr(A_MINSTRET, 32'hFFFF_FFFF);
        wr(A_MINSTRETH, 32'h5);
        instret_i = 1'b1;
        wr(A_MINSTRETH, 32'h7);
        instret_i = 1'b0;
        sb.push_back(32'hFFFF_FFFF); rd(A_MINSTRET, d); e = sb.pop_front(); nvec++;
        if (d !== e) begin nmis++; $display("FAIL minstret_no_inc_on_wr: got %h want %h", d, e); end
        sb.push_back(32'h7); rd(A_MINSTRETH, d); e = sb.pop_front(); nvec++;
        if (d !== e) begin nmis++; $display("FAIL minstreth_wr: got %h want %h", d, e); end
        instret_i = 1'b1;
        @(negedge clk); instret_i = 1'b0;
        @(negedge clk);
        sb.push_back(32'h0); rd(A_MINSTRET, d); e = sb.pop_front(); nvec++;
        if (d !== e) begin nmis++; $display("FAIL minstret_carry_lo: got %h want %h", d, e); end
        sb.push_back(32'h8); rd(A_MINSTRETH, d); e = sb.pop_front(); nvec++;
        if (d !== e) begin nmis++; $display("FAIL minstret_carry_hi: got %h want %h", d, e); end
        wr(A_MCYCLE, 32'hFFFF_FFFF);
        wr(A_MCYCLEH, 32'hFFFF_FFFF);
        @(negedge clk);
        sb.push_back(32'h0); rd(A_MCYCLE, d); e = sb.pop_front(); nvec++;
        if (d !== e) begin nmis++; $display("FAIL mcycle_wrap_lo: got %h want %h", d, e); end
        sb.push_back(32'h0); rd(A_MCYCLEH, d); e = sb.pop_front(); nvec++;
        if (d !== e) begin nmis++; $display("FAIL mcycle_wrap_hi: got %h want %h", d, e); end
    endtask

    task automatic test_priority;
        wr(A_MSTATUS, 32'h8);
        trap_i = 1'b1; mret_i = 1'b1; trap_pc_i = 32'h104;
        wr(A_MSTATUS, 32'h0);
        trap_i = 1'b0; mret_i = 1'b0;
        sb.push_back(32'h0000_1880); rd(A_MSTATUS, d); e = sb.pop_front(); nvec++;
        if (d !== e) begin nmis++; $display("FAIL prio_all_mie1: got %h want %h", d, e); end
        wr(A_MSTATUS, 32'h80);
        trap_i = 1'b1; mret_i = 1'b1;
        wr(A_MSTATUS, 32'h8);
        trap_i = 1'b0; mret_i = 1'b0;
        sb.push_back(32'h0000_1800); rd(A_MSTATUS, d); e = sb.pop_front(); nvec++;
        if (d !== e) begin nmis++; $display("FAIL prio_trap_over_mret: got %h want %h", d, e); end
        wr(A_MSTATUS, 32'h80);
        mret_i = 1'b1;
        wr(A_MSTATUS, 32'h8);
        mret_i = 1'b0;
        sb.push_back(32'h0000_1888); rd(A_MSTATUS, d); e = sb.pop_front(); nvec++;
        if (d !== e) begin nmis++; $display("FAIL prio_mret_over_we: got %h want %h", d, e); end
        trap_i = 1'b1; trap_pc_i = 32'h204;
        wr(A_MSCRATCH, 32'hCAFE_F00D);
        trap_i = 1'b0;
        sb.push_back(32'hCAFE_F00D); rd(A_MSCRATCH, d); e = sb.pop_front(); nvec++;
        if (d !== e) begin nmis++; $display("FAIL prio_we_untouched: got %h want %h", d, e); end
        sb.push_back(32'h204); rd(A_MEPC, d); e = sb.pop_front(); nvec++;
        if (d !== e) begin nmis++; $display("FAIL prio_trap_mepc: got %h want %h", d, e); end
        trap_i = 1'b1; trap_pc_i = 32'h303;
        wr(A_MEPC, 32'h44);
        trap_i = 1'b0;
        sb.push_back(32'h300); rd(A_MEPC, d); e = sb.pop_front(); nvec++;
        if (d !== e) begin nmis++; $display("FAIL prio_trap_over_we_mepc: got %h want %h", d, e); end
    endtask

    task automatic test_reset_mid;
        rst = 1'b1; trap_i = 1'b1; trap_pc_i = 32'h400;
        wr(A_MSCRATCH, 32'h1111);
        rst = 1'b0; trap_i = 1'b0;
        sb.push_back(32'h0); rd(A_MSCRATCH, d); e = sb.pop_front(); nvec++;
        if (d !== e) begin nmis++; $display("FAIL rstmid_mscratch: got %h want %h", d, e); end
        sb.push_back(32'h0); d = mepc_o; e = sb.pop_front(); nvec++;
        if (d !== e) begin nmis++; $display("FAIL rstmid_mepc: got %h want %h", d, e); end
        sb.push_back(32'h0000_1800); rd(A_MSTATUS, d); e = sb.pop_front(); nvec++;
        if (d !== e) begin nmis++; $display("FAIL rstmid_mstatus: got %h want %h", d, e); end
        sb.push_back(32'h0); d = mtvec_o; e = sb.pop_front(); nvec++;
        if (d !== e) begin nmis++; $display("FAIL rstmid_mtvec: got %h want %h", d, e); end
        sb.push_back(32'h0); rd(A_MCYCLEH, d); e = sb.pop_front(); nvec++;
        if (d !== e) begin nmis++; $display("FAIL rstmid_mcycleh: got %h want %h", d, e); end
        sb.push_back(32'h0); rd(A_MIE, d); e = sb.pop_front(); nvec++;
        if (d !== e) begin nmis++; $display("FAIL rstmid_mie: got %h want %h", d, e); end
    endtask

    initial begin
        repeat (2) @(negedge clk);
        rst = 1'b0;
        test_reset;
        test_write_masks;
        test_trap_mret;
        test_irq;
        test_counters;
        test_priority;
        test_reset_mid;
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule
